exa_crosb_out_vc_sched: RTL and testbench
=========================================

Name: exa_crosb_out_vc_sched

Overview:
- Per-output-port packet scheduler for the VC crossbar; one instance sits beside each crossbar output/s2e pair.
- Arbitrates among input ports requesting this output, each request naming a target output VC.
- Keeps credit counters mirroring the s2e per-VC FIFO free space.
- Holds a grant for a whole packet, gates each beat on credit, and drives the crossbar output mux select and the s2e VC select.

Parameters:
- input_num, 4, number of requesting input ports.
- vc_num, 2, virtual channels per priority.
- prio_num, 2, priority classes; total output VCs VT = vc_num*prio_num.
- out_fifo_depth, 40, slots per output VC FIFO; reset value of each credit counter.
- Derived localparams: IW = $clog2(input_num), VW = $clog2(VT), CW = $clog2(out_fifo_depth+1).
- WD_CYCLES, 1024, stall timeout; used only with the optional feature.

Ports:
- ACLK  in  1  clock.
- ARESETN  in  1  asynchronous active-low reset.
- i_req  in  input_num  input k requests this output.
- i_req_vc  in  input_num*VW  requested output VC of input k, in slice k.
- i_beat_valid  in  1  tvalid of the muxed stream from the granted input.
- i_beat_last  in  1  tlast of the muxed stream.
- i_beat_ready  in  1  s2e ready.
- i_credit_ret  in  VT  one pulse per freed slot, per VC.
- o_grant  out  input_num  one-hot grant to the cts of the selected input.
- o_sel_input  out  IW  crossbar mux select.
- o_sel_vc  out  VW  output VC for s2e.
- o_xfer_en  out  1  beat may move this cycle.
- o_busy  out  1  state is XFER.
- o_credits  out  VT*CW  current credit of each VC.
- o_credit_err  out  1  sticky overflow flag.

Behaviour:
- Reset (async, ARESETN=0):
  - state IDLE; o_grant=0, o_sel_input=0, o_sel_vc=0, o_busy=0, o_xfer_en=0, o_credit_err=0.
  - Every credit = out_fifo_depth; rr_ptr=0.
  - Reset mid-packet drops the grant immediately; no partial state survives.
- Eligible input: i_req[k] && credit[i_req_vc[k]] != 0.
- IDLE:
  - If any input is eligible, pick the first eligible index scanning rr_ptr, rr_ptr+1, ... modulo input_num.
  - Register o_grant, o_sel_input=k and o_sel_vc=i_req_vc[k], then go to XFER.
  - Latency: request at cycle t gives the grant visible at t+1.
  - No eligible input: stay in IDLE, outputs unchanged except the grant stays 0.
- XFER:
  - o_xfer_en = (credit[o_sel_vc] != 0), combinational.
  - beat = i_beat_valid && i_beat_ready && o_xfer_en.
  - o_sel_vc and o_sel_input are frozen for the whole packet; i_req/i_req_vc changes are ignored.
  - beat && i_beat_last: next cycle go to IDLE with o_grant=0 and rr_ptr=(winner+1) mod input_num.
  - Result: one idle cycle between packets; back-to-back grants to different inputs are therefore ≥2 cycles apart.
- Credits, per VC v:
  - Decrement on a beat when v==o_sel_vc.
  - Increment on i_credit_ret[v].
  - Both in the same cycle: value unchanged.
  - Increment at out_fifo_depth saturates and sets o_credit_err (sticky until reset).
  - Decrement at 0 cannot occur because o_xfer_en gates it.
- Credit reaching 0 mid-packet: the grant is held and o_xfer_en=0 until a return arrives; no re-arbitration.
- Single-beat packet (last on first beat): valid; IDLE→XFER→IDLE.
- Bit widths: rr_ptr wraps at input_num even when input_num is not a power of two.

Optional Feature:
- Macro: EXA_CROSB_SCHED_WATCHDOG_EN.
- With the macro defined:
  - A counter in XFER increments on each cycle without a beat and clears on a beat.
  - Reaching WD_CYCLES: force IDLE, drop the grant, advance rr_ptr past the winner, and pulse an extra output o_wd_timeout (1 cycle).
  - Credits are untouched.
- Without the macro: no counter, no o_wd_timeout port; XFER waits indefinitely.

Test Plan:
- Reset then i_req=4'b0001 with vc=2, 3-beat packet, ready=1 → grant 0001 at t+1, three beats, credit[2] goes 40→37, IDLE after last, rr_ptr=1.
- i_req=4'b1111 held, 1-beat packets → grant order 0,1,2,3,0, each grant separated by one IDLE cycle.
- Credit exhaustion: 40 single-beat packets to VC0 with no returns → credit[0]=0; a 41st request to VC0 is not granted while a VC1 request is granted; one i_credit_ret[0] pulse → VC0 request granted.
- Beat and i_credit_ret on the same VC in the same cycle → credit value unchanged; return at credit 40 → stays 40, o_credit_err=1.
- Mid-packet ARESETN pulse → o_grant=0 asynchronously, credits=40, state IDLE.
- With EXA_CROSB_SCHED_WATCHDOG_EN and WD_CYCLES=16: grant, then valid=0 for 16 cycles → o_wd_timeout pulse, grant dropped, next requester served.

Source files
------------

// File: rtl/exa_crosb_out_vc_sched.sv
// Per-output-port VC scheduler: round-robin packet arbitration, per-VC credit tracking and beat gating.
// Optional stall watchdog (adds o_wd_timeout) is built when EXA_CROSB_SCHED_WATCHDOG_EN is defined.
module exa_crosb_out_vc_sched #(
   parameter int input_num      = 4,
   parameter int vc_num         = 2,
   parameter int prio_num       = 2,
   parameter int out_fifo_depth = 40,
`ifdef EXA_CROSB_SCHED_WATCHDOG_EN
   parameter int WD_CYCLES      = 1024,
`endif
   localparam int VT = vc_num * prio_num,
   localparam int IW = $clog2(input_num),
   localparam int VW = $clog2(VT),
   localparam int CW = $clog2(out_fifo_depth + 1)
) (
   input  logic                  ACLK,
   input  logic                  ARESETN,
   input  logic [input_num-1:0]  i_req,
   input  logic [input_num*VW-1:0] i_req_vc,
   input  logic                  i_beat_valid,
   input  logic                  i_beat_last,
   input  logic                  i_beat_ready,
   input  logic [VT-1:0]         i_credit_ret,
   output logic [input_num-1:0]  o_grant,
   output logic [IW-1:0]         o_sel_input,
   output logic [VW-1:0]         o_sel_vc,
   output logic                  o_xfer_en,
   output logic                  o_busy,
   output logic [VT*CW-1:0]      o_credits,
`ifdef EXA_CROSB_SCHED_WATCHDOG_EN
   output logic                  o_credit_err,
   output logic                  o_wd_timeout
`else
   output logic                  o_credit_err
`endif
);

   typedef enum logic {IDLE, XFER} state_t;

   localparam logic [CW-1:0] DEPTH = CW'(out_fifo_depth);

   state_t               state_q, state_d;
   logic [input_num-1:0] grant_q, grant_d;
   logic [IW-1:0]        sel_input_q, sel_input_d;
   logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
   logic [VW-1:0]        sel_vc_q, sel_vc_d;
   logic [CW-1:0]        cred_q [VT];
   logic [CW-1:0]        cred_d [VT];
   logic                 err_q, err_d;

   logic                 beat;
   logic                 wd_hit;
   logic                 found;
   logic [IW-1:0]        win_idx;
   logic [VW-1:0]        win_vc;
   int                   scan_idx;

   assign o_xfer_en = (state_q == XFER) && (cred_q[sel_vc_q] != '0);
   assign beat      = i_beat_valid && i_beat_ready && o_xfer_en;

   // Scan from rr_ptr upward; the modulo keeps the wrap correct for non-power-of-two input counts.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      found    = 1'b0;
      win_idx  = '0;
      win_vc   = '0;
      scan_idx = 0;
      for (int i = 0; i < input_num; i++) begin
         scan_idx = (int'(rr_ptr_q) + i) % input_num;
         if (!found && i_req[scan_idx] &&
             (cred_q[i_req_vc[scan_idx*VW +: VW]] != '0)) begin
            found   = 1'b1;
            win_idx = IW'(scan_idx);
            win_vc  = i_req_vc[scan_idx*VW +: VW];
         end
      end
   end

`ifdef EXA_CROSB_SCHED_WATCHDOG_EN
   localparam int WW = $clog2(WD_CYCLES + 1);

   logic [WW-1:0] wd_cnt_q, wd_cnt_d;
   logic          wd_to_q;

   // Fires on the WD_CYCLES-th consecutive cycle in XFER without a beat.
   assign wd_hit = (state_q == XFER) && !beat && (wd_cnt_q == WW'(WD_CYCLES - 1));

   always_comb begin
      wd_cnt_d = '0;
      if ((state_q == XFER) && !beat && !wd_hit) begin
         wd_cnt_d = wd_cnt_q + WW'(1);
      end
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         wd_cnt_q <= '0;
         wd_to_q  <= 1'b0;
      end else begin
         wd_cnt_q <= wd_cnt_d;
         wd_to_q  <= wd_hit;
      end
   end

   assign o_wd_timeout = wd_to_q;
`else
   assign wd_hit = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      sel_input_d = sel_input_q;
      sel_vc_d    = sel_vc_q;
      rr_ptr_d    = rr_ptr_q;
      case (state_q)
         IDLE: begin
            grant_d = '0;
            if (found) begin
               state_d          = XFER;
               grant_d[win_idx] = 1'b1;
               sel_input_d      = win_idx;
               sel_vc_d         = win_vc;
            end
         end
         XFER: begin
            // Select lines stay frozen until the packet ends; request changes are ignored here.
            if ((beat && i_beat_last) || wd_hit) begin
               state_d  = IDLE;
               grant_d  = '0;
               rr_ptr_d = IW'((int'(sel_input_q) + 1) % input_num);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // A simultaneous beat and return on the same VC cancel out.
   always_comb begin
      err_d = err_q;
      for (int v = 0; v < VT; v++) begin
         cred_d[v] = cred_q[v];
         if (i_credit_ret[v] && !(beat && (sel_vc_q == VW'(v)))) begin
            if (cred_q[v] == DEPTH) begin
               err_d = 1'b1;
            end else begin
               cred_d[v] = cred_q[v] + CW'(1);
            end
         end else if (!i_credit_ret[v] && beat && (sel_vc_q == VW'(v))) begin
            cred_d[v] = cred_q[v] - CW'(1);
         end
      end
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state_q     <= IDLE;
         grant_q     <= '0;
         sel_input_q <= '0;
         sel_vc_q    <= '0;
         rr_ptr_q    <= '0;
         err_q       <= 1'b0;
         // NOTE: the credit array is reset element by element; it is state that must mirror an empty FIFO.
         for (int v = 0; v < VT; v++) begin
            cred_q[v] <= DEPTH;
         end
      end else begin
         // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
         state_q     <= state_d;
         grant_q     <= grant_d;
         sel_input_q <= sel_input_d;
         sel_vc_q    <= sel_vc_d;
         rr_ptr_q    <= rr_ptr_d;
         err_q       <= err_d;
         cred_q      <= cred_d;
      end
   end

   for (genvar v = 0; v < VT; v++) begin : g_cred_out
      assign o_credits[v*CW +: CW] = cred_q[v];
   end

   assign o_grant      = grant_q;
   assign o_sel_input  = sel_input_q;
   assign o_sel_vc     = sel_vc_q;
   assign o_busy       = (state_q == XFER);
   assign o_credit_err = err_q;

endmodule

// File: tb/tb_exa_crosb_out_vc_sched.sv
// Self-checking bench for exa_crosb_out_vc_sched: vector table, directed corner sequences and
// randomized traffic against a packet-level reference model.
module tb_exa_crosb_out_vc_sched;

   localparam int N     = 4;
   localparam int VT    = 4;
   localparam int VW    = 2;
   localparam int IW    = 2;
   localparam int CW    = 6;
   localparam int DEPTH = 40;
`ifdef EXA_CROSB_SCHED_WATCHDOG_EN
   localparam int WD    = 16;
`endif

   logic              ACLK    = 1'b0;
   logic              ARESETN = 1'b1;
   logic [N-1:0]      i_req;
   logic [N*VW-1:0]   i_req_vc;
   logic              i_beat_valid;
   logic              i_beat_last;
   logic              i_beat_ready;
   logic [VT-1:0]     i_credit_ret;
   logic [N-1:0]      o_grant;
   logic [IW-1:0]     o_sel_input;
   logic [VW-1:0]     o_sel_vc;
   logic              o_xfer_en;
   logic              o_busy;
   logic [VT*CW-1:0]  o_credits;
   logic              o_credit_err;
`ifdef EXA_CROSB_SCHED_WATCHDOG_EN
   logic              o_wd_timeout;
`endif

   always #5 ACLK = ~ACLK;

   exa_crosb_out_vc_sched #(
      .input_num      (N),
      .vc_num         (2),
      .prio_num       (2),
`ifdef EXA_CROSB_SCHED_WATCHDOG_EN
      .WD_CYCLES      (WD),
`endif
      .out_fifo_depth (DEPTH)
   ) dut (
      .ACLK         (ACLK),
      .ARESETN      (ARESETN),
      .i_req        (i_req),
      .i_req_vc     (i_req_vc),
      .i_beat_valid (i_beat_valid),
      .i_beat_last  (i_beat_last),
      .i_beat_ready (i_beat_ready),
      .i_credit_ret (i_credit_ret),
      .o_grant      (o_grant),
      .o_sel_input  (o_sel_input),
      .o_sel_vc     (o_sel_vc),
      .o_xfer_en    (o_xfer_en),
      .o_busy       (o_busy),
      .o_credits    (o_credits),
`ifdef EXA_CROSB_SCHED_WATCHDOG_EN
      .o_wd_timeout (o_wd_timeout),
`endif
      .o_credit_err (o_credit_err)
   );

   int vectors     = 0;
   int miscompares = 0;

   // Packet-level model: who owns the output, on which VC, and how many free slots each VC has.
   int m_busy, m_win, m_vc, m_rr, m_err, m_wd, m_to;
   int m_cred [VT];

   typedef struct {
      logic [N-1:0]    req;
      logic [N*VW-1:0] req_vc;
      logic            valid;
      logic            last;
      logic            ready;
      logic [VT-1:0]   ret;
      logic [N-1:0]    e_grant;
      logic            e_busy;
      logic            e_xen;
   } vec_t;

   vec_t tbl [14];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_busy = 0; m_win = 0; m_vc = 0; m_rr = 0; m_err = 0; m_wd = 0; m_to = 0;
      for (int v = 0; v < VT; v++) m_cred[v] = DEPTH;
   endtask

   task automatic model_step();
      int beat, old_vc, k, kv;
      beat   = (m_busy != 0) && i_beat_valid && i_beat_ready && (m_cred[m_vc] > 0);
      old_vc = m_vc;
      m_to   = 0;
      if (m_busy == 0) begin
         for (int j = 0; j < N; j++) begin
            k  = (m_rr + j) % N;
            kv = int'(i_req_vc[k*VW +: VW]);
            if (m_busy == 0 && i_req[k] && m_cred[kv] > 0) begin
               m_busy = 1; m_win = k; m_vc = kv;
            end
         end
      end else if (beat && i_beat_last) begin
         m_busy = 0;
         m_rr   = (m_win + 1) % N;
      end
`ifdef EXA_CROSB_SCHED_WATCHDOG_EN
      else if (beat) m_wd = 0;
      else begin
         m_wd++;
         if (m_wd == WD) begin
            m_busy = 0; m_rr = (m_win + 1) % N; m_to = 1;
         end
      end
`endif
      if (m_busy == 0) m_wd = 0;
      for (int v = 0; v < VT; v++) begin
         if (i_credit_ret[v] && !(beat && v == old_vc)) begin
            if (m_cred[v] == DEPTH) m_err = 1;
            else m_cred[v]++;
         end else if (!i_credit_ret[v] && beat && v == old_vc) begin
            m_cred[v]--;
         end
      end
   endtask

   task automatic compare_all(input string tag);
      logic [VT*CW-1:0] ec;
      for (int v = 0; v < VT; v++) ec[v*CW +: CW] = CW'(m_cred[v]);
      check({tag, ".grant"},   64'(o_grant),     (m_busy != 0) ? (64'd1 << m_win) : 64'd0);
      check({tag, ".busy"},    64'(o_busy),      64'(m_busy != 0));
      check({tag, ".sel_in"},  64'(o_sel_input), 64'(m_win));
      check({tag, ".sel_vc"},  64'(o_sel_vc),    64'(m_vc));
      check({tag, ".xfer_en"}, 64'(o_xfer_en),   64'((m_busy != 0) && (m_cred[m_vc] > 0)));
      check({tag, ".credits"}, 64'(o_credits),   64'(ec));
      check({tag, ".err"},     64'(o_credit_err), 64'(m_err != 0));
`ifdef EXA_CROSB_SCHED_WATCHDOG_EN
      check({tag, ".wd_to"},   64'(o_wd_timeout), 64'(m_to != 0));
`endif
   endtask

   task automatic tick(input string tag);
      model_step();
      @(posedge ACLK);
      #1;
      compare_all(tag);
   endtask

   task automatic idle_inputs();
      i_req = '0; i_req_vc = '0; i_beat_valid = 1'b0; i_beat_last = 1'b0;
      i_beat_ready = 1'b1; i_credit_ret = '0;
   endtask

   // Asserted mid-cycle so the async path is what clears the outputs.
   task automatic do_reset(input string tag);
      ARESETN = 1'b0;
      #2;
      model_reset();
      check({tag, ".grant0"}, 64'(o_grant), 64'd0);
      check({tag, ".busy0"},  64'(o_busy),  64'd0);
      compare_all(tag);
      @(posedge ACLK);
      #1;
      ARESETN = 1'b1;
   endtask

   function automatic int cred_of(input int v);
      return int'(o_credits[v*CW +: CW]);
   endfunction

   initial begin
      //            req      req_vc  val   last  rdy   ret      grant    busy  xen
      tbl[0]  = '{4'b0001, 8'h02, 1'b0, 1'b0, 1'b1, 4'h0, 4'b0001, 1'b1, 1'b1};
      tbl[1]  = '{4'b0000, 8'h00, 1'b1, 1'b0, 1'b1, 4'h0, 4'b0001, 1'b1, 1'b1};
      tbl[2]  = '{4'b0000, 8'h00, 1'b1, 1'b0, 1'b1, 4'h0, 4'b0001, 1'b1, 1'b1};
      tbl[3]  = '{4'b0000, 8'h00, 1'b1, 1'b1, 1'b1, 4'h0, 4'b0000, 1'b0, 1'b0};
      tbl[4]  = '{4'b1111, 8'h00, 1'b0, 1'b0, 1'b1, 4'h0, 4'b0010, 1'b1, 1'b1};
      tbl[5]  = '{4'b1111, 8'h00, 1'b1, 1'b1, 1'b1, 4'h0, 4'b0000, 1'b0, 1'b0};
      tbl[6]  = '{4'b1111, 8'h00, 1'b0, 1'b0, 1'b1, 4'h0, 4'b0100, 1'b1, 1'b1};
      tbl[7]  = '{4'b1111, 8'h00, 1'b1, 1'b1, 1'b1, 4'h0, 4'b0000, 1'b0, 1'b0};
      tbl[8]  = '{4'b1111, 8'h00, 1'b0, 1'b0, 1'b1, 4'h0, 4'b1000, 1'b1, 1'b1};
      tbl[9]  = '{4'b1111, 8'h00, 1'b1, 1'b1, 1'b1, 4'h0, 4'b0000, 1'b0, 1'b0};
      tbl[10] = '{4'b1111, 8'h00, 1'b0, 1'b0, 1'b1, 4'h0, 4'b0001, 1'b1, 1'b1};
      tbl[11] = '{4'b1111, 8'h00, 1'b1, 1'b1, 1'b1, 4'h0, 4'b0000, 1'b0, 1'b0};
      tbl[12] = '{4'b1111, 8'h00, 1'b0, 1'b0, 1'b1, 4'h0, 4'b0010, 1'b1, 1'b1};
      tbl[13] = '{4'b0000, 8'h00, 1'b1, 1'b1, 1'b1, 4'h0, 4'b0000, 1'b0, 1'b0};

      idle_inputs();
      do_reset("por");

      // 3-beat packet on VC2, then round-robin over held requests with 1-beat packets.
      for (int i = 0; i < 14; i++) begin
         i_req = tbl[i].req; i_req_vc = tbl[i].req_vc;
         i_beat_valid = tbl[i].valid; i_beat_last = tbl[i].last;
         i_beat_ready = tbl[i].ready; i_credit_ret = tbl[i].ret;
         tick("tbl");
         check($sformatf("tbl%0d.grant", i), 64'(o_grant),   64'(tbl[i].e_grant));
         check($sformatf("tbl%0d.busy", i),  64'(o_busy),    64'(tbl[i].e_busy));
         check($sformatf("tbl%0d.xen", i),   64'(o_xfer_en), 64'(tbl[i].e_xen));
      end
      check("tbl.cred2", 64'(cred_of(2)), 64'd37);
      check("tbl.cred0", 64'(cred_of(0)), 64'd35);

      // Exhaust VC0 with 40 single-beat packets, no returns.
      idle_inputs();
      do_reset("rst_exh");
      for (int p = 0; p < DEPTH; p++) begin
         i_req = 4'b0001; i_req_vc = '0; i_beat_valid = 1'b0; i_beat_last = 1'b0;
         tick("exh_req");
         i_req = '0; i_beat_valid = 1'b1; i_beat_last = 1'b1;
         tick("exh_beat");
      end
      check("exh.cred0", 64'(cred_of(0)), 64'd0);
      // rr_ptr is now 1: input1 (VC0) is skipped, input0 (VC1) wins.
      i_req = 4'b0011; i_req_vc = 8'b0000_0001; i_beat_valid = 1'b0; i_beat_last = 1'b0;
      tick("skip");
      check("skip.grant", 64'(o_grant), 64'h1);
      i_req = '0; i_beat_valid = 1'b1; i_beat_last = 1'b1;
      tick("skip_beat");
      i_req = 4'b0010; i_req_vc = '0; i_beat_valid = 1'b0; i_beat_last = 1'b0;
      tick("nocred");
      check("nocred.grant", 64'(o_grant), 64'h0);
      i_credit_ret = 4'b0001;
      tick("ret");
      check("ret.grant", 64'(o_grant), 64'h0);
      check("ret.cred0", 64'(cred_of(0)), 64'd1);
      i_credit_ret = '0;
      tick("after_ret");
      check("after_ret.grant", 64'(o_grant), 64'h2);

      // Beat and return on VC0 in the same cycle, then a return to a full VC.
      i_req = '0; i_beat_valid = 1'b1; i_beat_last = 1'b0; i_credit_ret = 4'b0001;
      tick("both");
      check("both.cred0", 64'(cred_of(0)), 64'd1);
      i_credit_ret = '0; i_beat_last = 1'b1;
      tick("last");
      check("last.cred0", 64'(cred_of(0)), 64'd0);
      i_beat_valid = 1'b0; i_beat_last = 1'b0; i_credit_ret = 4'b1000;
      tick("ovf");
      check("ovf.cred3", 64'(cred_of(3)), 64'd40);
      check("ovf.err", 64'(o_credit_err), 64'd1);
      i_credit_ret = '0;
      tick("ovf_sticky");
      check("ovf_sticky.err", 64'(o_credit_err), 64'd1);

      // Mid-packet reset.
      i_req = 4'b0100; i_req_vc = 8'b0011_0000;
      tick("mid_req");
      check("mid_req.grant", 64'(o_grant), 64'h4);
      i_req = '0; i_beat_valid = 1'b1;
      tick("mid_beat");
      do_reset("rst_mid");
      check("rst_mid.cred3", 64'(cred_of(3)), 64'd40);
      check("rst_mid.err", 64'(o_credit_err), 64'd0);

`ifdef EXA_CROSB_SCHED_WATCHDOG_EN
      idle_inputs();
      i_req = 4'b0011;
      tick("wd_req");
      check("wd_req.grant", 64'(o_grant), 64'h1);
      for (int c = 0; c < WD; c++) tick("wd_wait");
      check("wd.timeout", 64'(o_wd_timeout), 64'd1);
      check("wd.grant", 64'(o_grant), 64'h0);
      tick("wd_next");
      check("wd_next.grant", 64'(o_grant), 64'h2);
      check("wd_next.timeout", 64'(o_wd_timeout), 64'd0);
      do_reset("rst_wd");
`endif

      // Randomized traffic against the model.
      idle_inputs();
      for (int c = 0; c < 3000; c++) begin
         i_req        = N'($urandom);
         i_req_vc     = (N*VW)'($urandom);
         i_beat_valid = ($urandom_range(0, 3) != 0);
         i_beat_ready = ($urandom_range(0, 3) != 0);
         i_beat_last  = ($urandom_range(0, 2) == 0);
         for (int v = 0; v < VT; v++) i_credit_ret[v] = ($urandom_range(0, 7) == 0);
         tick("rnd");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
